// File: rtl/ita_weight_arbiter.sv
// ita_weight_arbiter: round-robin arbiter that shares the single weight-buffer
// fill port among N_REQ weight streamers. A grant is held for a full burst of
// BURST_LEN beats so one buffer half is never filled from two sources.
module ita_weight_arbiter #(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = 128,
   parameter int BURST_LEN = 8
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             flush_i,
   input  logic [N_REQ-1:0]                 req_valid_i,
   output logic [N_REQ-1:0]                 req_ready_o,
   input  logic [N_REQ-1:0][DATA_W-1:0]     req_data_i,
   output logic                             inp_weight_valid_o,
   input  logic                             inp_weight_ready_i,
   output logic [DATA_W-1:0]                inp_weight_o,
   output logic                             grant_valid_o,
   output logic [$clog2(N_REQ)-1:0]         grant_id_o,
   output logic                             burst_done_o,
   output logic [$clog2(N_REQ)-1:0]         burst_id_o
);

   localparam int ID_W  = $clog2(N_REQ);
   localparam int CNT_W = $clog2(BURST_LEN + 1);

   typedef enum logic {IDLE, LOCKED} state_e;

   state_e             state_q, state_d;
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]    grant_q, grant_d;
   logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic               burst_done_q, burst_done_d;
   logic [ID_W-1:0]    burst_id_q, burst_id_d;

   logic               win_found;
   logic [ID_W-1:0]    win_id;
   logic               handshake;
   logic               last_beat;

   // Round-robin search: first valid requester starting at rr_ptr_q, wrapping mod N_REQ.
   always_comb begin
      logic [ID_W-1:0] idx;
      win_found = 1'b0;
      win_id    = '0;
      // Scan from the farthest offset down so the nearest valid requester wins last.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
         if (req_valid_i[idx]) begin
            win_found = 1'b1;
            win_id    = idx;
         end
      end
   end

   // Output decode: the locked requester is passed straight through to the buffer.
   always_comb begin
      // NOTE: every output gets a default first so no path through the block leaves a latch.
      req_ready_o        = '0;
      inp_weight_valid_o = 1'b0;
      inp_weight_o       = '0;
      grant_valid_o      = 1'b0;
      grant_id_o         = '0;
      if (state_q == LOCKED) begin
         grant_valid_o         = 1'b1;
         grant_id_o            = grant_q;
         inp_weight_valid_o    = req_valid_i[grant_q];
         inp_weight_o          = req_data_i[grant_q];
         req_ready_o[grant_q]  = inp_weight_ready_i;
      end
   end

   assign handshake    = inp_weight_valid_o & inp_weight_ready_i;
   assign last_beat    = (beat_cnt_q == CNT_W'(BURST_LEN - 1));
   assign burst_done_o = burst_done_q;
   assign burst_id_o   = burst_id_q;

   // Next-state logic: arbitrate in IDLE, count beats while LOCKED, flush overrides all.
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      grant_d      = grant_q;
      beat_cnt_d   = beat_cnt_q;
      burst_done_d = 1'b0;
      burst_id_d   = burst_id_q;
      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               grant_d    = win_id;
               beat_cnt_d = '0;
               state_d    = LOCKED;
            end
         end
         LOCKED: begin
            if (handshake) begin
               if (last_beat) begin
                  beat_cnt_d   = '0;
                  rr_ptr_d     = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
                  state_d      = IDLE;
                  burst_done_d = 1'b1;
                  burst_id_d   = grant_q;
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // An aborted burst is dropped silently and the pointer keeps its place.
      if (flush_i) begin
         state_d      = IDLE;
         grant_d      = grant_q;
         beat_cnt_d   = '0;
         rr_ptr_d     = rr_ptr_q;
         burst_done_d = 1'b0;
         burst_id_d   = burst_id_q;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         grant_q      <= '0;
         beat_cnt_q   <= '0;
         burst_done_q <= 1'b0;
         burst_id_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         grant_q      <= grant_d;
         beat_cnt_q   <= beat_cnt_d;
         burst_done_q <= burst_done_d;
         burst_id_q   <= burst_id_d;
      end
   end

endmodule

// File: tb/tb_ita_weight_arbiter.sv
// Scoreboard bench for ita_weight_arbiter: stimulus pushes the expected beat
// stream and burst completions; a negedge monitor pops and compares.
module tb_ita_weight_arbiter;

   logic                  clk_i = 1'b0;
   logic                  rst_i;
   logic                  flush_i;
   logic [3:0]            req_valid_i;
   logic [3:0]            req_ready_o;
   logic [3:0][127:0]     req_data_i;
   logic                  inp_weight_valid_o;
   logic                  inp_weight_ready_i;
   logic [127:0]          inp_weight_o;
   logic                  grant_valid_o;
   logic [1:0]            grant_id_o;
   logic                  burst_done_o;
   logic [1:0]            burst_id_o;

   ita_weight_arbiter #(.N_REQ(4), .DATA_W(128), .BURST_LEN(8)) dut (
      .clk_i              (clk_i),
      .rst_i              (rst_i),
      .flush_i            (flush_i),
      .req_valid_i        (req_valid_i),
      .req_ready_o        (req_ready_o),
      .req_data_i         (req_data_i),
      .inp_weight_valid_o (inp_weight_valid_o),
      .inp_weight_ready_i (inp_weight_ready_i),
      .inp_weight_o       (inp_weight_o),
      .grant_valid_o      (grant_valid_o),
      .grant_id_o         (grant_id_o),
      .burst_done_o       (burst_done_o),
      .burst_id_o         (burst_id_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int           id;
      logic [127:0] data;
   } beat_t;

   beat_t      sb_q[$];
   int         done_q[$];
   int         total = 0;
   int         bad   = 0;

   // Source model: each requester streams a numbered sequence until stop_at.
   int         seq[4];
   int         stop_at[4];
   logic [3:0] en;
   logic [3:0] hold;
   logic [3:0] fire_q;

   function automatic logic [127:0] mk(int r, int s);
      return {32'(r), 32'(s), 32'hC0FFEE00 ^ 32'(r * 7 + s), ~32'(s * 3 + r)};
   endfunction

   task automatic check(string name, logic [127:0] act, logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         req_valid_i[i] = en[i] && !hold[i] && (seq[i] != stop_at[i]);
         req_data_i[i]  = mk(i, seq[i]);
      end
   endtask

   // Advance one clock; sources step past beats accepted at that edge.
   task automatic cycle();
      @(posedge clk_i);
      #1;
      for (int i = 0; i < 4; i++)
         if (fire_q[i]) seq[i]++;
      drive();
   endtask

   task automatic push_burst(int r, int first, int n, bit done);
      beat_t b;
      for (int k = 0; k < n; k++) begin
         b.id   = r;
         b.data = mk(r, first + k);
         sb_q.push_back(b);
      end
      if (done) done_q.push_back(r);
   endtask

   task automatic drain(int max, bit toggle);
      int n = 0;
      while ((sb_q.size() != 0 || done_q.size() != 0) && n < max) begin
         if (toggle) begin
            @(negedge clk_i);
            if (grant_valid_o && !inp_weight_ready_i)
               check("valid_not_gated", inp_weight_valid_o, 1);
         end
         cycle();
         if (toggle) inp_weight_ready_i = ~inp_weight_ready_i;
         n++;
      end
      check("drain_beats", sb_q.size(), 0);
      check("drain_done", done_q.size(), 0);
      sb_q.delete();
      done_q.delete();
      inp_weight_ready_i = 1'b1;
      en = '0;
      drive();
      repeat (2) cycle();
   endtask

   // Source-side handshake sampling, used by cycle() to step sequences.
   always @(negedge clk_i) begin
      for (int i = 0; i < 4; i++)
         fire_q[i] = req_valid_i[i] & req_ready_o[i];
   end

   // Monitor: compare every transferred beat and every completion pulse.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (inp_weight_valid_o && inp_weight_ready_i) begin
            if (sb_q.size() == 0) begin
               check("unexpected_beat", inp_weight_o, 0);
            end else begin
               beat_t e;
               e = sb_q.pop_front();
               check("beat_data", inp_weight_o, e.data);
               check("beat_src", grant_id_o, e.id);
               check("beat_ready", req_ready_o, 4'b0001 << e.id);
            end
         end
         if (burst_done_o) begin
            if (done_q.size() == 0) begin
               check("unexpected_done", burst_id_o, 0);
            end else begin
               int id;
               id = done_q.pop_front();
               check("done_id", burst_id_o, id);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s1, s2, s3, n;
      rst_i = 1'b1;
      flush_i = 1'b0;
      inp_weight_ready_i = 1'b0;
      en = '0;
      hold = '0;
      for (int i = 0; i < 4; i++) begin
         seq[i] = 0;
         stop_at[i] = 0;
      end
      drive();

      // Reset state.
      @(negedge clk_i);
      check("rst_grant_valid", grant_valid_o, 0);
      check("rst_req_ready", req_ready_o, 0);
      check("rst_wvalid", inp_weight_valid_o, 0);
      check("rst_done", burst_done_o, 0);

      // Test 1: single requester, continuous ready: 1 bubble, 8 beats, done pulse.
      en[0] = 1'b1;
      stop_at[0] = 8;
      inp_weight_ready_i = 1'b1;
      drive();
      push_burst(0, 0, 8, 1);
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk_i);
         if (c == 1) begin
            check("t1_idle_bubble", grant_valid_o, 0);
         end else if (c <= 9) begin
            check("t1_locked", grant_valid_o, 1);
            check("t1_gid", grant_id_o, 0);
            check("t1_wvalid", inp_weight_valid_o, 1);
         end else begin
            check("t1_done_cycle", burst_done_o, 1);
            check("t1_back_idle", grant_valid_o, 0);
         end
         cycle();
      end
      drain(20, 0);

      // Test 2: all requesters valid from rr_ptr=0: order 0,1,2,3,0.
      rst_i = 1'b1;
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      en = 4'b1111;
      stop_at[0] = seq[0] + 16;
      for (int i = 1; i < 4; i++) stop_at[i] = seq[i] + 8;
      push_burst(0, seq[0], 8, 1);
      push_burst(1, seq[1], 8, 1);
      push_burst(2, seq[2], 8, 1);
      push_burst(3, seq[3], 8, 1);
      push_burst(0, seq[0] + 8, 8, 1);
      drive();
      drain(100, 0);

      // Test 3: granted req1 stalls after 3 beats; req2 must wait.
      en = 4'b0110;
      s1 = seq[1];
      s2 = seq[2];
      stop_at[1] = s1 + 8;
      stop_at[2] = s2 + 8;
      push_burst(1, s1, 8, 1);
      push_burst(2, s2, 8, 1);
      drive();
      n = 0;
      while (seq[1] - s1 < 3 && n < 50) begin
         cycle();
         n++;
      end
      hold[1] = 1'b1;
      drive();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_i);
         check("t3_grant_held", grant_id_o, 1);
         check("t3_locked", grant_valid_o, 1);
         check("t3_ready_only_1", req_ready_o, 4'b0010);
         check("t3_no_beat", inp_weight_valid_o, 0);
         cycle();
      end
      hold[1] = 1'b0;
      drive();
      drain(100, 0);

      // Test 4: toggling buffer ready on a req1 burst.
      en = 4'b0010;
      s1 = seq[1];
      stop_at[1] = s1 + 8;
      push_burst(1, s1, 8, 1);
      drive();
      drain(100, 1);

      // Test 5: flush after 5 beats of a req2 burst; req2 re-wins, then req3.
      en = 4'b1100;
      s2 = seq[2];
      s3 = seq[3];
      stop_at[2] = s2 + 14;
      stop_at[3] = s3 + 8;
      push_burst(2, s2, 6, 0);
      push_burst(2, s2 + 6, 8, 1);
      push_burst(3, s3, 8, 1);
      drive();
      n = 0;
      while (seq[2] - s2 < 5 && n < 50) begin
         cycle();
         n++;
      end
      flush_i = 1'b1;
      @(negedge clk_i);
      check("t5_flush_cycle_locked", grant_valid_o, 1);
      check("t5_flush_cycle_beat", inp_weight_valid_o, 1);
      cycle();
      flush_i = 1'b0;
      @(negedge clk_i);
      check("t5_idle_after_flush", grant_valid_o, 0);
      check("t5_no_done", burst_done_o, 0);
      cycle();
      @(negedge clk_i);
      check("t5_regrant_2", grant_id_o, 2);
      cycle();
      drain(100, 0);

      // Test 6: req2 burst moves rr_ptr to 3; reset mid req3 burst restarts at 0.
      en = 4'b0100;
      stop_at[2] = seq[2] + 8;
      push_burst(2, seq[2], 8, 1);
      drive();
      drain(50, 0);
      en = 4'b1010;
      s1 = seq[1];
      s3 = seq[3];
      stop_at[1] = s1 + 8;
      stop_at[3] = s3 + 11;
      push_burst(3, s3, 3, 0);
      drive();
      n = 0;
      while (seq[3] - s3 < 3 && n < 50) begin
         cycle();
         n++;
      end
      #2 rst_i = 1'b1;
      #1;
      check("t6_rst_ready", req_ready_o, 0);
      check("t6_rst_wvalid", inp_weight_valid_o, 0);
      check("t6_rst_wdata", inp_weight_o, 0);
      check("t6_rst_gvalid", grant_valid_o, 0);
      check("t6_rst_gid", grant_id_o, 0);
      check("t6_rst_done", burst_done_o, 0);
      check("t6_rst_bid", burst_id_o, 0);
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      push_burst(1, s1, 8, 1);
      push_burst(3, s3 + 3, 8, 1);
      @(negedge clk_i);
      check("t6_idle_after_rst", grant_valid_o, 0);
      cycle();
      @(negedge clk_i);
      check("t6_grant_low", grant_id_o, 1);
      cycle();
      drain(100, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
